// File: rtl/tone_phase_generator.sv
// Divide-by-N phase accumulator feeding a 256-entry sine table.
// Tone, octave and start/stop changes only take effect at the 255->0 phase wrap.
module tone_phase_generator #(
    parameter int PRESCALE_W = 10,
    parameter int ADDR_W     = 8,
    parameter int OCT_W      = 2
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  enable_sound,
    input  logic [PRESCALE_W-1:0] preScaleValue,
    input  logic [OCT_W-1:0]      octave,
    output logic [ADDR_W-1:0]     sin_addr,
    output logic                  sample_tick,
    output logic                  playing
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_STOPPING
    } state_t;

    state_t                 state_q, state_d;
    logic [PRESCALE_W-1:0]  cnt_q, cnt_d;
    logic [PRESCALE_W-1:0]  div_active_q, div_active_d;
    logic [ADDR_W-1:0]      sin_addr_q, sin_addr_d;
    logic                   sample_tick_q, sample_tick_d;
    logic                   playing_q, playing_d;

    logic [PRESCALE_W-1:0]  shifted;
    logic [PRESCALE_W-1:0]  eff;
    logic                   tick_now;
    logic                   wrap_now;

    // Clamp keeps tick spacing at two clocks minimum, so ticks never touch.
    always_comb begin
        shifted  = preScaleValue >> octave;
        eff      = (shifted < PRESCALE_W'(2)) ? PRESCALE_W'(2) : shifted;
        tick_now = (state_q != S_IDLE) && (cnt_q == '0);
        wrap_now = tick_now && (sin_addr_q == '1);
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (enable_sound) state_d = S_RUN;
            end
            S_RUN: begin
                if (!enable_sound) state_d = S_STOPPING;
            end
            S_STOPPING: begin
                if (enable_sound)  state_d = S_RUN;
                else if (wrap_now) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d         = cnt_q;
        div_active_d  = div_active_q;
        sin_addr_d    = sin_addr_q;
        sample_tick_d = 1'b0;
        playing_d     = (state_d != S_IDLE);

        if (state_q == S_IDLE) begin
            sin_addr_d = '0;
            cnt_d      = '0;
            if (enable_sound) begin
                div_active_d = eff;
                cnt_d        = eff - PRESCALE_W'(1);
            end
        end else if (tick_now) begin
            sample_tick_d = 1'b1;
            sin_addr_d    = sin_addr_q + ADDR_W'(1);
            if (wrap_now) begin
                // Only point where a new divider is adopted.
                div_active_d = eff;
                cnt_d        = (state_d == S_IDLE) ? '0 : eff - PRESCALE_W'(1);
            end else begin
                cnt_d = div_active_q - PRESCALE_W'(1);
            end
        end else begin
            cnt_d = cnt_q - PRESCALE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            cnt_q         <= '0;
            div_active_q  <= '0;
            sin_addr_q    <= '0;
            sample_tick_q <= 1'b0;
            playing_q     <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            div_active_q  <= div_active_d;
            sin_addr_q    <= sin_addr_d;
            sample_tick_q <= sample_tick_d;
            playing_q     <= playing_d;
        end
    end

    assign sin_addr    = sin_addr_q;
    assign sample_tick = sample_tick_q;
    assign playing     = playing_q;

endmodule

// File: tb/tb_tone_phase_generator.sv
// Self-checking bench for tone_phase_generator: tick spacing, phase sequence,
// wrap-aligned tone changes, stop/resume, reset and divider clamp.
module tb_tone_phase_generator;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       enable_sound = 1'b0;
    logic [9:0] preScaleValue = '0;
    logic [1:0] octave = '0;
    logic [7:0] sin_addr;
    logic       sample_tick;
    logic       playing;

    int n_checks = 0;
    int n_fail   = 0;

    tone_phase_generator #(
        .PRESCALE_W(10),
        .ADDR_W(8),
        .OCT_W(2)
    ) dut (
        .clk(clk),
        .resetN(resetN),
        .enable_sound(enable_sound),
        .preScaleValue(preScaleValue),
        .octave(octave),
        .sin_addr(sin_addr),
        .sample_tick(sample_tick),
        .playing(playing)
    );

    always #5 clk = ~clk;

    // Reference divider: integer division by 2^octave, floored at 2.
    function automatic int model_eff(input int ps, input int oct);
        int e;
        e = ps / (1 << oct);
        return (e < 2) ? 2 : e;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    // Measures clocks until the next sampled tick; ok=0 if the budget expires.
    task automatic wait_tick(input int budget, output int gap, output logic ok);
        gap = 0;
        ok  = 1'b0;
        while (gap < budget && !ok) begin
            @(negedge clk);
            gap++;
            if (sample_tick === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        enable_sound = 1'b0;
        step();
        step();
        resetN = 1'b1;
        step();
    endtask

    task automatic start_tone(input int ps, input int oct, input string name);
        preScaleValue = 10'(ps);
        octave = 2'(oct);
        enable_sound = 1'b1;
        step();
        n_checks++;
        if (playing !== 1'b1) begin
            n_fail++;
            $display("FAIL %s start: playing=%b required 1", name, playing);
        end
    endtask

    // Runs n ticks, each expected e clocks apart with incrementing address.
    task automatic run_ticks(input int n, input int e, inout int addr,
                             input logic exp_play, input string name);
        int gap;
        logic ok;
        for (int i = 0; i < n; i++) begin
            wait_tick(2 * e + 10, gap, ok);
            addr = (addr + 1) % 256;
            n_checks++;
            if (!ok || gap != e || sin_addr !== 8'(addr) || playing !== exp_play) begin
                n_fail++;
                $display("FAIL %s tick%0d: ok=%b gap=%0d addr=%0d play=%b required gap=%0d addr=%0d play=%b",
                         name, i, ok, gap, sin_addr, playing, e, addr, exp_play);
            end
        end
    endtask

    task automatic test_reset();
        int e, addr;
        int gap;
        logic ok;
        resetN = 1'b0;
        step();
        step();
        n_checks++;
        if ({sin_addr, sample_tick, playing} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_values: addr=%0d tick=%b play=%b required 0 0 0", sin_addr, sample_tick, playing);
        end
        resetN = 1'b1;
        e = $urandom_range(4, 9);
        addr = 0;
        start_tone(e, 0, "reset");
        run_ticks(8'h57, e, addr, 1'b1, "reset_pre");
        step();
        resetN = 1'b0;
        step();
        n_checks++;
        if ({sin_addr, sample_tick, playing} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_mid_run: addr=%0d tick=%b play=%b required 0 0 0", sin_addr, sample_tick, playing);
        end
        step();
        step();
        e = $urandom_range(4, 9);
        preScaleValue = 10'(e);
        resetN = 1'b1;
        step();
        wait_tick(2 * e + 10, gap, ok);
        n_checks++;
        if (!ok || gap != e || sin_addr !== 8'd1) begin
            n_fail++;
            $display("FAIL reset_restart: ok=%b gap=%0d addr=%0d required gap=%0d addr=1", ok, gap, sin_addr, e);
        end
    endtask

    task automatic test_base_tone();
        int addr = 0;
        do_reset();
        start_tone(10'h1BB, 0, "base");
        run_ticks(20, 443, addr, 1'b1, "base");
    endtask

    task automatic test_octave();
        int addr = 0;
        do_reset();
        start_tone(10'h2EA, 2, "octave");
        run_ticks(20, model_eff(10'h2EA, 2), addr, 1'b1, "octave");
    endtask

    task automatic test_full_wrap();
        int ps, oct, e, addr, total, gap;
        logic ok;
        ps = $urandom_range(16, 240);
        oct = $urandom_range(2, 3);
        e = model_eff(ps, oct);
        addr = 0;
        total = 0;
        do_reset();
        start_tone(ps, oct, "wrap");
        for (int i = 0; i < 256; i++) begin
            wait_tick(2 * e + 10, gap, ok);
            total += gap;
            if (!ok) break;
        end
        n_checks++;
        if (total != 256 * e || sin_addr !== 8'd0 || playing !== 1'b1) begin
            n_fail++;
            $display("FAIL full_wrap: clocks=%0d addr=%0d play=%b required clocks=%0d addr=0 play=1",
                     total, sin_addr, playing, 256 * e);
        end
    endtask

    task automatic test_tone_change();
        int addr = 0;
        do_reset();
        start_tone(10'h2EA, 3, "tone_chg");
        run_ticks(100, model_eff(10'h2EA, 3), addr, 1'b1, "tone_chg_a");
        preScaleValue = 10'h1BB;
        run_ticks(156, model_eff(10'h2EA, 3), addr, 1'b1, "tone_chg_b");
        run_ticks(3, model_eff(10'h1BB, 3), addr, 1'b1, "tone_chg_c");
    endtask

    task automatic test_stop_resume();
        int e, addr, extra_ticks, gap;
        logic ok;
        logic any_play;

        e = $urandom_range(2, 5);
        addr = 0;
        do_reset();
        start_tone(e, 0, "stop");
        run_ticks(10, e, addr, 1'b1, "stop_a");
        enable_sound = 1'b0;
        run_ticks(245, e, addr, 1'b1, "stop_b");
        run_ticks(1, e, addr, 1'b0, "stop_final");
        extra_ticks = 0;
        any_play = 1'b0;
        for (int i = 0; i < 4 * e; i++) begin
            step();
            if (sample_tick === 1'b1) extra_ticks++;
            if (playing !== 1'b0) any_play = 1'b1;
        end
        n_checks++;
        if (extra_ticks != 0 || any_play || sin_addr !== 8'd0) begin
            n_fail++;
            $display("FAIL stop_idle: ticks=%0d play=%b addr=%0d required 0 0 0", extra_ticks, any_play, sin_addr);
        end

        e = $urandom_range(2, 5);
        addr = 0;
        do_reset();
        start_tone(e, 0, "resume");
        run_ticks(10, e, addr, 1'b1, "resume_a");
        enable_sound = 1'b0;
        run_ticks(190, e, addr, 1'b1, "resume_b");
        enable_sound = 1'b1;
        run_ticks(60, e, addr, 1'b1, "resume_c");

        // Enable dropped exactly on the wrap edge: one whole further period plays.
        e = $urandom_range(2, 4);
        addr = 0;
        do_reset();
        start_tone(e, 0, "wrap_stop");
        run_ticks(255, e, addr, 1'b1, "wrap_stop_a");
        repeat (e - 1) step();
        enable_sound = 1'b0;
        wait_tick(10, gap, ok);
        n_checks++;
        if (!ok || gap != 1 || sin_addr !== 8'd0 || playing !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_stop_edge: ok=%b gap=%0d addr=%0d play=%b required gap=1 addr=0 play=1",
                     ok, gap, sin_addr, playing);
        end
        addr = 0;
        run_ticks(255, e, addr, 1'b1, "wrap_stop_b");
        run_ticks(1, e, addr, 1'b0, "wrap_stop_final");
    endtask

    task automatic test_clamp();
        int ps_tab[5];
        int oct_tab[5];
        int addr;
        ps_tab  = '{3, 0, 1, 0, 0};
        oct_tab = '{1, 0, 0, 3, 1};
        ps_tab[4] = $urandom_range(0, 3);
        for (int c = 0; c < 5; c++) begin
            addr = 0;
            do_reset();
            start_tone(ps_tab[c], oct_tab[c], "clamp");
            run_ticks(10, model_eff(ps_tab[c], oct_tab[c]), addr, 1'b1, "clamp");
        end
    endtask

    initial begin
        test_reset();
        test_base_tone();
        test_octave();
        test_full_wrap();
        test_tone_change();
        test_stop_resume();
        test_clamp();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
